// File: rtl/uart_frame_checker_mc.sv
// uart_frame_checker_mc
//   Observational N-channel UART line checker. Each channel decodes one serial line
//   (start, 5..8 data bits LSB first, optional parity, one or two stop bits), pulses
//   frame/glitch/parity/framing events and keeps a saturating per-channel error count.
//
//   Ports
//     pclk, preset           clock, asynchronous active-high reset
//     chk_en                 0 forces every channel to idle and suppresses pulses
//     cfg_div                pclk cycles per bit (values below 4 act as 4)
//     cfg_dbits              data bits 00=5 .. 11=8
//     cfg_par_en/par_odd     parity present / odd parity
//     cfg_stop2              check a second stop bit
//     err_clr                synchronous clear of all error counters (wins over increments)
//     uart_net[NUM_CH]       serial lines, idle high
//     frame_vld/par_err/frm_err   one-cycle pulses at frame end
//     frame_data[8*NUM_CH]   last received byte per channel, zero-extended, held
//     glitch_err             one-cycle pulse when the start bit is high at mid-bit
//     err_cnt[CNT_W*NUM_CH]  saturating error counters
//
//   Build option: define UART_CHK_SYNC_EN to insert a 2-flop synchroniser (reset to 1)
//   on every line; all event timings then move 2 pclk later.
module uart_frame_checker_mc #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    chk_en,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [1:0]              cfg_dbits,
  input  logic                    cfg_par_en,
  input  logic                    cfg_par_odd,
  input  logic                    cfg_stop2,
  input  logic                    err_clr,
  input  logic [NUM_CH-1:0]       uart_net,
  output logic [NUM_CH-1:0]       frame_vld,
  output logic [NUM_CH*8-1:0]     frame_data,
  output logic [NUM_CH-1:0]       glitch_err,
  output logic [NUM_CH-1:0]       par_err,
  output logic [NUM_CH-1:0]       frm_err,
  output logic [NUM_CH*CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StWaitHi
  } state_e;

  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(4);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic line;

`ifdef UART_CHK_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
        sync_q <= 2'b11;
      end else begin
        sync_q <= {sync_q[0], uart_net[gi]};
      end
    end
    assign line = sync_q[1];
`else
    assign line = uart_net[gi];
`endif

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       fdata_q, fdata_d;
    logic [1:0]       dbits_q, dbits_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             stop2_q, stop2_d;
    logic             pend_par_q, pend_par_d;
    logic             pend_frm_q, pend_frm_d;
    logic             prev_q;
    logic             vld_q, vld_d;
    logic             gl_q, gl_d;
    logic             pe_q, pe_d;
    logic             fe_q, fe_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W:0]   ecnt_sum;
    logic             mid_start;
    logic             mid_bit;
    logic             exp_par;

    assign mid_start = (cnt_q == (div_q >> 1));
    assign mid_bit   = (cnt_q == (div_q - DIV_W'(1)));
    assign exp_par   = par_odd_q ? ~^data_q : ^data_q;

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + DIV_W'(1);
      div_d      = div_q;
      bit_d      = bit_q;
      data_d     = data_q;
      fdata_d    = fdata_q;
      dbits_d    = dbits_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      stop2_d    = stop2_q;
      pend_par_d = pend_par_q;
      pend_frm_d = pend_frm_q;
      vld_d      = 1'b0;
      gl_d       = 1'b0;
      pe_d       = 1'b0;
      fe_d       = 1'b0;

      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (prev_q && !line) begin
            // Frame configuration is frozen here for the whole frame.
            state_d    = StStart;
            bit_d      = '0;
            data_d     = '0;
            pend_par_d = 1'b0;
            pend_frm_d = 1'b0;
            div_d      = (cfg_div < MinDiv) ? MinDiv : cfg_div;
            dbits_d    = cfg_dbits;
            par_en_d   = cfg_par_en;
            par_odd_d  = cfg_par_odd;
            stop2_d    = cfg_stop2;
          end
        end
        StStart: begin
          if (mid_start) begin
            cnt_d = '0;
            if (line) begin
              gl_d    = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (mid_bit) begin
            cnt_d          = '0;
            data_d[bit_q]  = line;
            bit_d          = bit_q + 3'd1;
            // Last data bit index is 4 + cfg_dbits.
            if (bit_q == {1'b1, dbits_q}) begin
              state_d = par_en_q ? StParity : StStop1;
            end
          end
        end
        StParity: begin
          if (mid_bit) begin
            cnt_d = '0;
            if (line != exp_par) begin
              pend_par_d = 1'b1;
            end
            state_d = StStop1;
          end
        end
        StStop1: begin
          if (mid_bit) begin
            cnt_d = '0;
            if (!line) begin
              pend_frm_d = 1'b1;
            end
            if (stop2_q && line) begin
              state_d = StStop2;
            end else begin
              vld_d   = 1'b1;
              fdata_d = data_q;
              pe_d    = pend_par_q;
              fe_d    = pend_frm_q | ~line;
              state_d = line ? StIdle : StWaitHi;
            end
          end
        end
        StStop2: begin
          if (mid_bit) begin
            cnt_d   = '0;
            vld_d   = 1'b1;
            fdata_d = data_q;
            pe_d    = pend_par_q;
            fe_d    = pend_frm_q | ~line;
            if (!line) begin
              pend_frm_d = 1'b1;
            end
            state_d = line ? StIdle : StWaitHi;
          end
        end
        StWaitHi: begin
          cnt_d = '0;
          if (line) begin
            state_d = StIdle;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase

      // Disabling drops any frame in progress, including its pending result.
      if (!chk_en) begin
        state_d = StIdle;
        cnt_d   = '0;
        vld_d   = 1'b0;
        gl_d    = 1'b0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        fdata_d = fdata_q;
      end
    end

    // At most 2 is added to a value <= max, so the extra MSB flags saturation.
    always_comb begin
      ecnt_sum = {1'b0, ecnt_q} + {{CNT_W{1'b0}}, gl_q} + {{CNT_W{1'b0}}, pe_q}
               + {{CNT_W{1'b0}}, fe_q};
      if (err_clr) begin
        ecnt_d = '0;
      end else if (ecnt_sum[CNT_W]) begin
        ecnt_d = '1;
      end else begin
        ecnt_d = ecnt_sum[CNT_W-1:0];
      end
    end

    always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        div_q      <= '0;
        bit_q      <= '0;
        data_q     <= '0;
        fdata_q    <= '0;
        dbits_q    <= '0;
        par_en_q   <= 1'b0;
        par_odd_q  <= 1'b0;
        stop2_q    <= 1'b0;
        pend_par_q <= 1'b0;
        pend_frm_q <= 1'b0;
        prev_q     <= 1'b1;
        vld_q      <= 1'b0;
        gl_q       <= 1'b0;
        pe_q       <= 1'b0;
        fe_q       <= 1'b0;
        ecnt_q     <= '0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        div_q      <= div_d;
        bit_q      <= bit_d;
        data_q     <= data_d;
        fdata_q    <= fdata_d;
        dbits_q    <= dbits_d;
        par_en_q   <= par_en_d;
        par_odd_q  <= par_odd_d;
        stop2_q    <= stop2_d;
        pend_par_q <= pend_par_d;
        pend_frm_q <= pend_frm_d;
        prev_q     <= line;
        vld_q      <= vld_d;
        gl_q       <= gl_d;
        pe_q       <= pe_d;
        fe_q       <= fe_d;
        ecnt_q     <= ecnt_d;
      end
    end

    assign frame_vld[gi]                = vld_q;
    assign glitch_err[gi]               = gl_q;
    assign par_err[gi]                  = pe_q;
    assign frm_err[gi]                  = fe_q;
    assign frame_data[8*gi +: 8]        = fdata_q;
    assign err_cnt[CNT_W*gi +: CNT_W]   = ecnt_q;
  end

endmodule

// File: tb/tb_uart_frame_checker_mc.sv
// Testbench for uart_frame_checker_mc: table-driven frames checked through a per-channel
// scoreboard, plus hand-written sequences for glitch, break/WAIT_HI, concurrency,
// saturation, clear priority, disable and reset corner cases.
module tb_uart_frame_checker_mc;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int CW  = 2;

  logic            pclk = 1'b0;
  logic            preset = 1'b1;
  logic            chk_en = 1'b1;
  logic [DW-1:0]   cfg_div = 16'd16;
  logic [1:0]      cfg_dbits = 2'd3;
  logic            cfg_par_en = 1'b0;
  logic            cfg_par_odd = 1'b0;
  logic            cfg_stop2 = 1'b0;
  logic            err_clr = 1'b0;
  logic            line [NCH];
  logic [NCH-1:0]  uart_net;
  logic [NCH-1:0]  frame_vld;
  logic [NCH*8-1:0] frame_data;
  logic [NCH-1:0]  glitch_err;
  logic [NCH-1:0]  par_err;
  logic [NCH-1:0]  frm_err;
  logic [NCH*CW-1:0] err_cnt;

  assign uart_net = {line[1], line[0]};

  uart_frame_checker_mc #(.NUM_CH(NCH), .DIV_W(DW), .CNT_W(CW)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .chk_en      (chk_en),
    .cfg_div     (cfg_div),
    .cfg_dbits   (cfg_dbits),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .err_clr     (err_clr),
    .uart_net    (uart_net),
    .frame_vld   (frame_vld),
    .frame_data  (frame_data),
    .glitch_err  (glitch_err),
    .par_err     (par_err),
    .frm_err     (frm_err),
    .err_cnt     (err_cnt)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic [1:0] dbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
    logic       pbit;
    logic       s1;
    logic       s2;
    int         cdiv;
    int         tdiv;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[9];

  int vld_cnt[NCH];
  int gl_cnt[NCH];
  int vld_cyc[NCH];
  int gl_cyc[NCH];
  int exp_cnt[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    if (ch == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  function automatic int sb_size(input int ch);
    return (ch == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(err_cnt[CW*ch +: CW]);
  endfunction

  // Drives one frame, called and returning on a negedge.
  task automatic send(input int ch, input logic [7:0] data, input int nbits, input logic has_par,
                      input logic pbit, input logic two_stop, input logic s1, input logic s2,
                      input int div, input int hold_low);
    line[ch] = 1'b0;
    repeat (div) @(negedge pclk);
    for (int k = 0; k < nbits; k++) begin
      line[ch] = data[k];
      repeat (div) @(negedge pclk);
    end
    if (has_par) begin
      line[ch] = pbit;
      repeat (div) @(negedge pclk);
    end
    line[ch] = s1;
    repeat (div) @(negedge pclk);
    if (two_stop) begin
      line[ch] = s2;
      repeat (div) @(negedge pclk);
    end
    if (hold_low > 0) begin
      line[ch] = 1'b0;
      repeat (hold_low) @(negedge pclk);
    end
    line[ch] = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge pclk);
    err_clr = 1'b0;
    @(negedge pclk);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pen, input logic odd, input logic st2,
                         input int div);
    cfg_dbits   = db;
    cfg_par_en  = pen;
    cfg_par_odd = odd;
    cfg_stop2   = st2;
    cfg_div     = DW'(div);
  endtask

  // Output monitor / scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!preset) begin
        for (int c = 0; c < NCH; c++) begin
          if (glitch_err[c]) begin
            gl_cnt[c]++;
            gl_cyc[c] = cyc;
          end
          if (frame_vld[c]) begin
            vld_cnt[c]++;
            vld_cyc[c] = cyc;
            if (sb_size(c) == 0) begin
              check("unexpected_frame", 32'd1, 32'd0);
            end else begin
              if (c == 0) e = sb0.pop_front();
              else e = sb1.pop_front();
              check("frame_data", 32'(frame_data[8*c +: 8]), 32'(e.data));
              check("par_err", 32'(par_err[c]), 32'(e.pe));
              check("frm_err", 32'(frm_err[c]), 32'(e.fe));
            end
          end else if (par_err[c] || frm_err[c]) begin
            check("err_without_vld", 32'({par_err[c], frm_err[c]}), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int v0;
    int g0;
    int found;
    logic [31:0] ec;
    vec_t v;

    line[0] = 1'b1;
    line[1] = 1'b1;

    vecs[0] = '{0, 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 16, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h35, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16, 16, 8'h35, 1'b1, 1'b0};
    vecs[2] = '{0, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 16, 8'h1F, 1'b0, 1'b0};
    vecs[3] = '{1, 8'h2A, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16, 16, 8'h2A, 1'b0, 1'b0};
    vecs[4] = '{0, 8'h81, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 16, 8'h81, 1'b0, 1'b1};
    vecs[5] = '{1, 8'hC3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16, 16, 8'hC3, 1'b0, 1'b0};
    vecs[6] = '{0, 8'h3C, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16, 16, 8'h3C, 1'b0, 1'b1};
    vecs[7] = '{1, 8'h7F, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16, 16, 8'h7F, 1'b1, 1'b0};
    // Divisor below the minimum behaves as 4.
    vecs[8] = '{0, 8'h6B, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 4, 8'h6B, 1'b0, 1'b0};

    repeat (3) @(negedge pclk);
    check("rst_frame_vld", 32'(frame_vld), 32'd0);
    check("rst_frame_data", 32'(frame_data), 32'd0);
    check("rst_glitch", 32'(glitch_err), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_frm_err", 32'(frm_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    preset = 1'b0;
    repeat (3) @(negedge pclk);

    for (int r = 0; r < 9; r++) begin
      v = vecs[r];
      set_cfg(v.dbits, v.par_en, v.par_odd, v.stop2, v.cdiv);
      v0 = vld_cnt[v.ch];
      push(v.ch, v.exp_data, v.exp_pe, v.exp_fe);
      s = cyc;
      send(v.ch, v.data, 5 + int'(v.dbits), v.par_en, v.pbit, v.stop2, v.s1, v.s2, v.tdiv, 0);
      repeat (20) @(negedge pclk);
      check("row_frame_seen", 32'(sb_size(v.ch)), 32'd0);
      check("row_vld_once", 32'(vld_cnt[v.ch] - v0), 32'd1);
      exp_cnt[v.ch] = sat(exp_cnt[v.ch] + int'(v.exp_pe) + int'(v.exp_fe));
      check("row_err_cnt", cnt_of(v.ch), 32'(exp_cnt[v.ch]));
      // 8 to mid-start, 9 bits of 16, 1 register stage.
      if (r == 0) check("latency_8n1", 32'(vld_cyc[0] - s - 1), 32'd153);
    end
    check("row_err_cnt_ch0_total", cnt_of(0), 32'd2);

    // Glitch: 4-cycle low pulse, start bit high at its mid-bit sample.
    pulse_clr();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16);
    g0 = gl_cnt[0];
    v0 = vld_cnt[0];
    s = cyc;
    line[0] = 1'b0;
    repeat (4) @(negedge pclk);
    line[0] = 1'b1;
    repeat (30) @(negedge pclk);
    check("glitch_seen", 32'(gl_cnt[0] - g0), 32'd1);
    check("glitch_latency", 32'(gl_cyc[0] - s - 1), 32'd9);
    check("glitch_no_vld", 32'(vld_cnt[0] - v0), 32'd0);
    exp_cnt[0] = 1;
    check("glitch_err_cnt", cnt_of(0), 32'd1);

    // Break: second stop low, line held low, then a clean frame after line returns high.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b1, 16);
    g0 = gl_cnt[0];
    push(0, 8'h96, 1'b0, 1'b1);
    send(0, 8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 40);
    repeat (5) @(negedge pclk);
    check("break_frame_seen", 32'(sb_size(0)), 32'd0);
    exp_cnt[0] = 2;
    check("break_err_cnt", cnt_of(0), 32'd2);
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16);
    push(0, 8'h3C, 1'b0, 1'b0);
    send(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0);
    repeat (20) @(negedge pclk);
    check("after_break_seen", 32'(sb_size(0)), 32'd0);
    check("after_break_err_cnt", cnt_of(0), 32'd2);
    check("after_break_no_glitch", 32'(gl_cnt[0] - g0), 32'd0);

    // Both channels concurrently.
    push(0, 8'h55, 1'b0, 1'b0);
    push(1, 8'hAA, 1'b0, 1'b0);
    fork
      send(0, 8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0);
      send(1, 8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0);
    join
    repeat (20) @(negedge pclk);
    check("dual_seen", 32'(sb_size(0) + sb_size(1)), 32'd0);
    check("dual_same_cycle", 32'(vld_cyc[0]), 32'(vld_cyc[1]));

    // Saturation with 2-bit counters: five parity errors on ch1.
    pulse_clr();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    set_cfg(2'd3, 1'b1, 1'b0, 1'b0, 16);
    for (int i = 0; i < 5; i++) begin
      push(1, 8'h01, 1'b1, 1'b0);
      send(1, 8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0);
      repeat (10) @(negedge pclk);
      exp_cnt[1] = sat(exp_cnt[1] + 1);
      check("sat_err_cnt", cnt_of(1), 32'(exp_cnt[1]));
    end

    // Clear coincident with an increment: clear wins.
    push(1, 8'h01, 1'b1, 1'b0);
    found = 0;
    fork
      send(1, 8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0);
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge pclk);
          if (par_err[1]) begin
            found = 1;
            break;
          end
        end
        if (found == 1) begin
          err_clr = 1'b1;
          @(negedge pclk);
          err_clr = 1'b0;
        end
      end
    join
    check("clr_wait_par_err", 32'(found), 32'd1);
    repeat (10) @(negedge pclk);
    exp_cnt[1] = 0;
    check("clr_priority", cnt_of(1), 32'd0);

    // Disable mid-frame: frame dropped, counters hold.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16);
    v0 = vld_cnt[0];
    ec = 32'(err_cnt);
    fork
      send(0, 8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 0);
      begin
        repeat (50) @(negedge pclk);
        chk_en = 1'b0;
      end
    join
    repeat (5) @(negedge pclk);
    chk_en = 1'b1;
    repeat (5) @(negedge pclk);
    check("dis_no_vld", 32'(vld_cnt[0] - v0), 32'd0);
    check("dis_cnt_hold", 32'(err_cnt), ec);
    push(0, 8'h42, 1'b0, 1'b1);
    send(0, 8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 0);
    repeat (20) @(negedge pclk);
    check("reen_seen", 32'(sb_size(0)), 32'd0);
    exp_cnt[0] = 1;
    check("reen_err_cnt", cnt_of(0), 32'd1);

    // Reset in the middle of ch1 data bits.
    v0 = vld_cnt[1];
    g0 = gl_cnt[1];
    line[1] = 1'b0;
    repeat (60) @(negedge pclk);
    preset = 1'b1;
    line[1] = 1'b1;
    @(negedge pclk);
    check("mid_rst_frame_data", 32'(frame_data), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_pulses", 32'({frame_vld, glitch_err, par_err, frm_err}), 32'd0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    repeat (200) @(negedge pclk);
    check("post_rst_no_vld", 32'(vld_cnt[1] - v0), 32'd0);
    check("post_rst_no_glitch", 32'(gl_cnt[1] - g0), 32'd0);
    push(1, 8'h5A, 1'b0, 1'b0);
    send(1, 8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0);
    repeat (20) @(negedge pclk);
    check("post_rst_frame_seen", 32'(sb_size(1)), 32'd0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
